fixedpt_display_ctrl: RTL and testbench
=======================================

FIXEDPT_DISPLAY_CTRL -- requirements
Module: fixedpt_display_ctrl

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 1000: clock cycles each display digit stays enabled; legal range 2..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: in_data holds a new value to display.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a value this cycle.
REQ-006 The block SHALL have port in_data, input, 8 bits: unsigned Q4.4 value; [7:4] is the integer part 0..15 and [3:0] is the fraction in sixteenths.
REQ-007 The block SHALL have port seg, output, 7 bits: active-high segments, bit order gfedcba (seg[0]=a).
REQ-008 The block SHALL have port an, output, 4 bits: one-hot, active-high digit enable; an[0] is the hundredths digit and an[3] is the integer-tens digit.
REQ-009 The block SHALL have port dp, output, 1 bit: active-high decimal point.
REQ-010 The block SHALL have port busy, output, 1 bit: a conversion is in progress.

Function
REQ-011 The block SHALL contain an FSM with states IDLE, CONV_INT, FRAC1, FRAC2 and LOAD; each non-IDLE state lasts exactly one cycle.
REQ-012 in_ready SHALL be 1 only in IDLE; busy SHALL be its inverse; both are decoded from state with no added register.
REQ-013 On the edge where in_valid=1 and in_ready=1: in_data captured to an internal register; state goes to CONV_INT.
REQ-014 State sequence SHALL be CONV_INT -> FRAC1 -> FRAC2 -> LOAD -> IDLE; in_data and in_valid are ignored outside IDLE.
REQ-015 CONV_INT SHALL set tens = 1 and units = int-10 if int >= 10; otherwise tens = 0 and units = int.
REQ-016 FRAC1 SHALL compute p = frac*10 (8 bits, max 150); tenths = p[7:4]; rem = p[3:0].
REQ-017 FRAC2 SHALL compute q = rem*10; hundredths = q[7:4]; the result is truncated, not rounded.
REQ-018 In LOAD, all four display digit registers SHALL update together on the same edge; the display never shows a partially converted value.
REQ-019 Latency SHALL be 4 cycles: accept at edge t0, display registers updated at edge t4, in_ready=1 again in the cycle after t4.
REQ-020 The maximum accept rate SHALL be one value per 5 cycles; back-to-back values with in_valid held high are accepted at t0, t5, ...
REQ-021 A scan counter SHALL count 0..SCAN_DIV-1 and wrap; on wrap, digit index idx advances 0->1->2->3->0.
REQ-022 an SHALL equal 1<<idx; dp SHALL be 1 exactly when idx=2.
REQ-023 seg SHALL be the encoding of the selected digit: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
REQ-024 Leading-zero blanking: when idx=3 and tens=0, seg SHALL be 0000000; digits 0..2 are never blanked.
REQ-025 The scan SHALL run continuously and independently of the FSM; a LOAD does not reset the scan counter or idx.
REQ-026 seg, an and dp SHALL be registered or decoded only from registers, so they are glitch-free relative to clk.

Reset
REQ-027 On rst_n=0, asynchronously: state=IDLE, all digit registers=0, scan counter=0, idx=0.
REQ-028 During reset the outputs SHALL be an=0001, seg=0111111, dp=0, in_ready=1, busy=0.
REQ-029 A reset during any conversion state SHALL abort the conversion with no LOAD; the display reads "0.00" after release.
REQ-030 The first accept SHALL be possible on the first rising edge after rst_n is released.

Verification
REQ-031 Reset check: SCAN_DIV=4 -> an cycles 0001,0010,0100,1000 with 4 cycles each; segs 0111111, 0111111, 0111111 (dp=1), 0000000.
REQ-032 in_data=0x0A with one-cycle valid -> after 4 cycles digits read blank, 0, 6, 2; hundredths seg=1011011, tenths seg=1111101.
REQ-033 in_data=0xFF -> digits read 1, 5, 9, 3 ("15.93"); an=1000 shows seg=0000110.
REQ-034 in_data=0x00 -> "0.00"; in_data=0x58 -> digits read blank, 5, 5, 0.
REQ-035 in_valid held high with values 0x10, then 0x20 -> accepts exactly 5 cycles apart; in_ready=0 for 4 cycles after each accept; display ends on "2.00".
REQ-036 0xA4 accepted, then rst_n pulsed low during FRAC1 -> display stays "0.00", in_ready=1; a new 0x34 afterwards -> "3.25".

Source files
------------

// File: rtl/fixedpt_display_ctrl_if.sv
// Value handshake into the display controller: the producer offers a Q4.4 value
// and the controller signals when it can take it.
interface fixedpt_display_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/fixedpt_display_ctrl.sv
// Converts an unsigned Q4.4 value into four decimal digits (tens, units, tenths,
// hundredths) and multiplexes them onto a 4-digit 7-segment display.
module fixedpt_display_ctrl #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  fixedpt_display_ctrl_if.slave       in_bus,
  output logic [6:0]                  seg,
  output logic [3:0]                  an,
  output logic                        dp,
  output logic                        busy
);

  typedef enum logic [2:0] {IDLE, CONV_INT, FRAC1, FRAC2, LOAD} state_t;

  state_t      state;
  logic [7:0]  data_reg;
  logic [3:0]  tens_w, units_w, tenths_w, hund_w, rem_w;
  logic [3:0]  tens_d, units_d, tenths_d, hund_d;
  logic [15:0] scan_cnt;
  logic [1:0]  idx;
  logic [7:0]  frac_p, rem_q;
  logic [3:0]  digit;

  assign in_bus.in_ready = (state == IDLE);
  assign busy            = (state != IDLE);

  assign frac_p = {4'd0, data_reg[3:0]} * 8'd10;
  assign rem_q  = {4'd0, rem_w} * 8'd10;

  // Working digits fill in over three cycles; the display copy only changes in LOAD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      data_reg <= 8'd0;
      tens_w   <= 4'd0;
      units_w  <= 4'd0;
      tenths_w <= 4'd0;
      hund_w   <= 4'd0;
      rem_w    <= 4'd0;
      tens_d   <= 4'd0;
      units_d  <= 4'd0;
      tenths_d <= 4'd0;
      hund_d   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_bus.in_valid) begin
            data_reg <= in_bus.in_data;
            state    <= CONV_INT;
          end
        end
        CONV_INT: begin
          if (data_reg[7:4] >= 4'd10) begin
            tens_w  <= 4'd1;
            units_w <= data_reg[7:4] - 4'd10;
          end else begin
            tens_w  <= 4'd0;
            units_w <= data_reg[7:4];
          end
          state <= FRAC1;
        end
        FRAC1: begin
          tenths_w <= frac_p[7:4];
          rem_w    <= frac_p[3:0];
          state    <= FRAC2;
        end
        FRAC2: begin
          hund_w <= rem_q[7:4];
          state  <= LOAD;
        end
        LOAD: begin
          tens_d   <= tens_w;
          units_d  <= units_w;
          tenths_d <= tenths_w;
          hund_d   <= hund_w;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= 16'd0;
      idx      <= 2'd0;
    end else if (scan_cnt == 16'(SCAN_DIV - 1)) begin
      scan_cnt <= 16'd0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 16'd1;
    end
  end

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    seg_encode = 7'b0111111;
      4'd1:    seg_encode = 7'b0000110;
      4'd2:    seg_encode = 7'b1011011;
      4'd3:    seg_encode = 7'b1001111;
      4'd4:    seg_encode = 7'b1100110;
      4'd5:    seg_encode = 7'b1101101;
      4'd6:    seg_encode = 7'b1111101;
      4'd7:    seg_encode = 7'b0000111;
      4'd8:    seg_encode = 7'b1111111;
      4'd9:    seg_encode = 7'b1101111;
      default: seg_encode = 7'b0000000;
    endcase
  endfunction

  // Pure decode of idx and the display registers, so outputs stay glitch-free
  always_comb begin
    digit = hund_d;
    case (idx)
      2'd0:    digit = hund_d;
      2'd1:    digit = tenths_d;
      2'd2:    digit = units_d;
      default: digit = tens_d;
    endcase
    seg = seg_encode(digit);
    if (idx == 2'd3 && tens_d == 4'd0) seg = 7'b0000000;
    an = 4'b0001 << idx;
    dp = (idx == 2'd2);
  end

endmodule

// File: tb/tb_fixedpt_display_ctrl.sv
// Self-checking bench: an arithmetic model of the displayed value and scan
// position is compared against the DUT every cycle, plus directed literal checks.
module tb_fixedpt_display_ctrl;

  localparam int SCAN = 4;
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       busy;
  int         checks = 0;
  int         errors = 0;

  fixedpt_display_ctrl_if bus ();

  fixedpt_display_ctrl #(.SCAN_DIV(SCAN)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_bus (bus.slave),
    .seg    (seg),
    .an     (an),
    .dp     (dp),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Model state: displayed value in hundredths, pending conversion countdown, cycles since reset
  int         m_disp;
  int         m_cnt;
  int         m_cycles;
  logic [7:0] m_pend;

  function automatic int to_hundredths(input logic [7:0] v);
    return int'(v[7:4]) * 100 + (int'(v[3:0]) * 100) / 16;
  endfunction

  function automatic logic [6:0] exp_seg(input int disp, input int pos);
    int d;
    case (pos)
      0:       d = disp % 10;
      1:       d = (disp / 10) % 10;
      2:       d = (disp / 100) % 10;
      default: d = disp / 1000;
    endcase
    if (pos == 3 && disp < 1000) return 7'b0000000;
    return SEG_TABLE[d];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_disp   <= 0;
      m_cnt    <= 0;
      m_cycles <= 0;
      m_pend   <= 8'd0;
    end else begin
      m_cycles <= m_cycles + 1;
      if (m_cnt == 0) begin
        if (bus.in_valid) begin
          m_pend <= bus.in_data;
          m_cnt  <= 4;
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) m_disp <= to_hundredths(m_pend);
      end
    end
  end

  always @(posedge clk) begin
    int         pos;
    logic [6:0] s_req;
    logic [3:0] an_req;
    logic       rdy_req;
    #1;
    pos     = (m_cycles / SCAN) % 4;
    s_req   = exp_seg(m_disp, pos);
    an_req  = 4'(1 << pos);
    rdy_req = (m_cnt == 0);
    checks++;
    if (seg !== s_req || an !== an_req || dp !== (pos == 2) ||
        bus.in_ready !== rdy_req || busy !== !rdy_req) begin
      errors++;
      $display("[TB] FAIL cycle_outputs t=%0t got seg=%b an=%b dp=%b rdy=%b busy=%b want seg=%b an=%b dp=%b rdy=%b busy=%b",
               $time, seg, an, dp, bus.in_ready, busy, s_req, an_req, pos == 2, rdy_req, !rdy_req);
    end
  end

  task automatic checkValue(input string name, input int actual, input int req);
    checks++;
    if (actual != req) begin
      errors++;
      $display("[TB] FAIL %s got %0d want %0d", name, actual, req);
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] an_sel,
                             input logic [6:0] seg_req, input logic dp_req);
    int waited = 0;
    @(negedge clk);
    while (an !== an_sel && waited < 4 * SCAN + 4) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (an !== an_sel) begin
      errors++;
      $display("[TB] FAIL %s timeout waiting for an=%b, got an=%b", name, an_sel, an);
    end else if (seg !== seg_req || dp !== dp_req) begin
      errors++;
      $display("[TB] FAIL %s got seg=%b dp=%b want seg=%b dp=%b", name, seg, dp, seg_req, dp_req);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] v);
    int waited = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    while (!bus.in_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    checkValue("accept_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    logic [6:0] scan_seg [4] = '{7'b0111111, 7'b0111111, 7'b0111111, 7'b0000000};
    logic [3:0] scan_an  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    int first_acc, second_acc, low_cnt;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    repeat (3) @(negedge clk);
    checkValue("reset_an", int'(an), 1);
    checkValue("reset_seg", int'(seg), 7'b0111111);
    checkValue("reset_dp", int'(dp), 0);
    checkValue("reset_ready", int'(bus.in_ready), 1);
    checkValue("reset_busy", int'(busy), 0);

    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      checkValue("scan_an", int'(an), int'(scan_an[i / 4]));
      checkValue("scan_seg", int'(seg), int'(scan_seg[i / 4]));
      checkValue("scan_dp", int'(dp), int'(i / 4 == 2));
      @(negedge clk);
    end

    applyStimulus(8'h0A);
    repeat (5) @(negedge clk);
    checkValue("model_0A", m_disp, 62);
    checkOutput("x0A_hund", 4'b0001, 7'b1011011, 1'b0);
    checkOutput("x0A_tenth", 4'b0010, 7'b1111101, 1'b0);
    checkOutput("x0A_units", 4'b0100, 7'b0111111, 1'b1);
    checkOutput("x0A_tens", 4'b1000, 7'b0000000, 1'b0);

    applyStimulus(8'hFF);
    repeat (5) @(negedge clk);
    checkValue("model_FF", m_disp, 1593);
    checkOutput("xFF_tens", 4'b1000, 7'b0000110, 1'b0);
    checkOutput("xFF_hund", 4'b0001, 7'b1001111, 1'b0);
    checkOutput("xFF_units", 4'b0100, 7'b1101101, 1'b1);

    applyStimulus(8'h00);
    repeat (5) @(negedge clk);
    checkValue("model_00", m_disp, 0);
    checkOutput("x00_units", 4'b0100, 7'b0111111, 1'b1);
    checkOutput("x00_tens", 4'b1000, 7'b0000000, 1'b0);

    applyStimulus(8'h58);
    repeat (5) @(negedge clk);
    checkValue("model_58", m_disp, 550);
    checkOutput("x58_units", 4'b0100, 7'b1101101, 1'b1);
    checkOutput("x58_hund", 4'b0001, 7'b0111111, 1'b0);
    checkOutput("x58_tenth", 4'b0010, 7'b1101101, 1'b0);

    // Held-valid stream: observe acceptance spacing at negedges
    first_acc  = -1;
    second_acc = -1;
    low_cnt    = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h10;
    for (int c = 0; c < 30 && second_acc < 0; c++) begin
      if (bus.in_ready) begin
        if (first_acc < 0) first_acc = c;
        else second_acc = c;
      end else if (first_acc >= 0) begin
        low_cnt++;
      end
      @(negedge clk);
      if (first_acc >= 0) bus.in_data = 8'h20;
    end
    bus.in_valid = 1'b0;
    checkValue("stream_second_seen", int'(second_acc >= 0), 1);
    checkValue("stream_gap", second_acc - first_acc, 5);
    checkValue("stream_ready_low", low_cnt, 4);
    repeat (5) @(negedge clk);
    checkValue("model_20", m_disp, 200);
    checkOutput("x20_units", 4'b0100, 7'b1011011, 1'b1);
    checkOutput("x20_hund", 4'b0001, 7'b0111111, 1'b0);

    applyStimulus(8'hA4);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkValue("abort_ready", int'(bus.in_ready), 1);
    checkValue("abort_model", m_disp, 0);
    repeat (6) @(negedge clk);
    checkValue("abort_ready_later", int'(bus.in_ready), 1);
    checkOutput("abort_units", 4'b0100, 7'b0111111, 1'b1);
    checkOutput("abort_tens", 4'b1000, 7'b0000000, 1'b0);

    applyStimulus(8'h34);
    repeat (5) @(negedge clk);
    checkValue("model_34", m_disp, 325);
    checkOutput("x34_hund", 4'b0001, 7'b1101101, 1'b0);
    checkOutput("x34_tenth", 4'b0010, 7'b1011011, 1'b0);
    checkOutput("x34_units", 4'b0100, 7'b1001111, 1'b1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
